// File: rtl/db_pkg.sv
// Shared debouncer constants and helpers, imported by every debouncer block.
package db_pkg;

  localparam int unsigned DefTickDiv     = 100000;
  localparam int unsigned DefStableTicks = 3;

  // Bits needed to hold values 0..value-1; value is expected to be >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/db_chan.sv
// One debounce channel: optional input synchroniser, confirmation counter, level and edge pulses.
// DB_MULTI_SYNC_EN inserts a 2-flop synchroniser in front of the counter logic.
module db_chan
  import db_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DefStableTicks
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  input  logic i_tick,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned SW_W = clog2(STABLE_TICKS + 1);

  logic            w_s;
  logic [SW_W-1:0] r_cnt;
  logic [SW_W-1:0] w_cnt_d;
  logic            r_db;
  logic            w_db_d;
  logic            r_rise;
  logic            w_rise_d;
  logic            r_fall;
  logic            w_fall_d;

`ifdef DB_MULTI_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_sw};
    end
  end

  assign w_s = r_sync[1];
`else
  assign w_s = i_sw;
`endif

  // Any sample equal to the current level restarts confirmation from scratch.
  always_comb begin
    w_cnt_d  = r_cnt;
    w_db_d   = r_db;
    w_rise_d = 1'b0;
    w_fall_d = 1'b0;
    if (w_s == r_db) begin
      w_cnt_d = '0;
    end else if (i_tick) begin
      if (r_cnt == SW_W'(STABLE_TICKS - 1)) begin
        w_db_d   = w_s;
        w_cnt_d  = '0;
        w_rise_d = w_s;
        w_fall_d = ~w_s;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_db   <= w_db_d;
      r_rise <= w_rise_d;
      r_fall <= w_fall_d;
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/db_multi.sv
// Multi-channel debouncer: shared sample-tick prescaler feeding CH independent db_chan instances.
// Define DB_MULTI_SYNC_EN to synchronise each raw input (adds 2 cycles of latency).
module db_multi
  import db_pkg::*;
#(
  parameter int unsigned CH           = 4,
  parameter int unsigned TICK_DIV     = DefTickDiv,
  parameter int unsigned STABLE_TICKS = DefStableTicks
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
);

  localparam int unsigned PW = clog2(TICK_DIV);

  logic [PW-1:0] r_pcnt;
  logic [PW-1:0] w_pcnt_d;
  logic          w_tick;

  assign w_tick   = (r_pcnt == PW'(TICK_DIV - 1));
  assign w_pcnt_d = w_tick ? '0 : r_pcnt + 1'b1;
  assign tick     = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= w_pcnt_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    db_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .i_sw  (sw[i]),
      .i_tick(w_tick),
      .o_db  (db[i]),
      .o_rise(rise[i]),
      .o_fall(fall[i])
    );
  end

endmodule
